// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search scheduler.
package rc4_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 24;
    localparam logic [23:0] KEY_MAX_DEFAULT   = 24'h3FFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } sched_state_t;

endpackage

// File: rtl/key_search_scheduler_core_picker.sv
// Lowest-index selector over a core mask, plus a popcount of a second mask.
module core_picker #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int unsigned CNT_W     = $clog2(NUM_CORES + 1)
) (
    input  logic [NUM_CORES-1:0] sel_mask,
    input  logic [NUM_CORES-1:0] cnt_mask,
    output logic [IDX_W-1:0]     pick_idx_c,
    output logic [CNT_W-1:0]     pick_cnt_c
);

    // Scan from the top so the lowest set index wins; count set bits of cnt_mask.
    always_comb begin
        pick_idx_c = '0;
        pick_cnt_c = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (sel_mask[i]) begin
                pick_idx_c = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            pick_cnt_c = pick_cnt_c + CNT_W'(cnt_mask[i]);
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// Dispatches candidate RC4 keys to idle cores and stops all cores on the first hit.
module key_search_scheduler
    import rc4_pkg::*;
#(
    parameter int unsigned          NUM_CORES = 4,
    parameter int unsigned          KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(KEY_MAX_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           core_abort,
    output logic                           busy,
    output logic                           found,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic                           exhausted,
    output logic [KEY_WIDTH:0]             keys_done
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);
    localparam int unsigned NK_W  = KEY_WIDTH + 1;
    // Extra top bit lets next_key step past an all-ones KEY_MAX without wrapping.
    localparam logic [NK_W-1:0] KEY_LIMIT = {1'b0, KEY_MAX};

    sched_state_t         state_q, state_n;
    logic [NK_W-1:0]      next_key_q, next_key_n;
    logic [NUM_CORES-1:0] busy_mask_q, busy_mask_n;
    logic [NUM_CORES-1:0] core_start_q, core_start_n;
    logic [KEY_WIDTH-1:0] core_key_q [NUM_CORES];
    logic [KEY_WIDTH-1:0] core_key_n [NUM_CORES];
    logic                 core_abort_q, core_abort_n;
    logic                 busy_q, busy_n;
    logic                 found_q, found_n;
    logic [KEY_WIDTH-1:0] found_key_q, found_key_n;
    logic                 exhausted_q, exhausted_n;
    logic [NK_W-1:0]      keys_done_q, keys_done_n;

    logic [NUM_CORES-1:0] done_valid_c, found_valid_c, idle_mask_c;
    logic [IDX_W-1:0]     idle_idx_c, found_idx_c;
    logic [CNT_W-1:0]     done_cnt_c, found_cnt_c;
    logic                 found_hit_c, can_dispatch_c;

    // Done pulses from cores we never started are dropped here.
    assign done_valid_c   = core_done & busy_mask_q;
    assign found_valid_c  = done_valid_c & core_found;
    assign idle_mask_c    = ~busy_mask_q;
    assign found_hit_c    = (found_cnt_c != '0);
    assign can_dispatch_c = (|idle_mask_c) && (next_key_q <= KEY_LIMIT);

    // Idle-core selection and completion count.
    core_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_idle_pick (
        .sel_mask   (idle_mask_c),
        .cnt_mask   (done_valid_c),
        .pick_idx_c (idle_idx_c),
        .pick_cnt_c (done_cnt_c)
    );

    // Found-priority encoding: lowest-index winner.
    core_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_found_pick (
        .sel_mask   (found_valid_c),
        .cnt_mask   (found_valid_c),
        .pick_idx_c (found_idx_c),
        .pick_cnt_c (found_cnt_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            next_key_q   <= '0;
            busy_mask_q  <= '0;
            core_start_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_key_q[i] <= '0;
            end
            core_abort_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            found_key_q  <= '0;
            exhausted_q  <= 1'b0;
            keys_done_q  <= '0;
        end else begin
            state_q      <= state_n;
            next_key_q   <= next_key_n;
            busy_mask_q  <= busy_mask_n;
            core_start_q <= core_start_n;
            core_key_q   <= core_key_n;
            core_abort_q <= core_abort_n;
            busy_q       <= busy_n;
            found_q      <= found_n;
            found_key_q  <= found_key_n;
            exhausted_q  <= exhausted_n;
            keys_done_q  <= keys_done_n;
        end
    end

    // Next-state, dispatch and completion bookkeeping.
    always_comb begin
        state_n      = state_q;
        next_key_n   = next_key_q;
        busy_mask_n  = busy_mask_q;
        core_start_n = '0;
        core_key_n   = core_key_q;
        core_abort_n = 1'b0;
        found_n      = found_q;
        found_key_n  = found_key_q;
        exhausted_n  = exhausted_q;
        keys_done_n  = keys_done_q;

        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                // A fresh search dispatches key 0 to core 0 immediately.
                if (start) begin
                    found_n         = 1'b0;
                    exhausted_n     = 1'b0;
                    keys_done_n     = '0;
                    busy_mask_n     = '0;
                    busy_mask_n[0]  = 1'b1;
                    core_start_n[0] = 1'b1;
                    core_key_n[0]   = '0;
                    next_key_n      = NK_W'(1);
                    state_n         = (NK_W'(1) > KEY_LIMIT) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (found_hit_c) begin
                    found_n      = 1'b1;
                    found_key_n  = core_key_q[found_idx_c];
                    core_abort_n = 1'b1;
                    busy_mask_n  = '0;
                    keys_done_n  = keys_done_q + NK_W'(done_cnt_c);
                    state_n      = ST_FOUND;
                end else if (stop) begin
                    core_abort_n = 1'b1;
                    busy_mask_n  = '0;
                    state_n      = ST_IDLE;
                end else begin
                    keys_done_n = keys_done_q + NK_W'(done_cnt_c);
                    busy_mask_n = busy_mask_q & ~done_valid_c;
                    if (state_q == ST_RUN) begin
                        // Idle mask comes from the registered busy bits, so a core
                        // finishing this cycle is only re-dispatched next cycle.
                        if (can_dispatch_c) begin
                            busy_mask_n[idle_idx_c]  = 1'b1;
                            core_start_n[idle_idx_c] = 1'b1;
                            core_key_n[idle_idx_c]   = next_key_q[KEY_WIDTH-1:0];
                            next_key_n               = next_key_q + NK_W'(1);
                        end
                        if (next_key_n > KEY_LIMIT) begin
                            state_n = ST_DRAIN;
                        end
                    end else if (busy_mask_n == '0) begin
                        exhausted_n = 1'b1;
                        state_n     = ST_EXHAUSTED;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n == ST_RUN) || (state_n == ST_DRAIN);
    end

    // Flatten per-core keys onto the output bus.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_out
        assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = core_key_q[g];
    end

    assign core_start = core_start_q;
    assign core_abort = core_abort_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign found_key  = found_key_q;
    assign exhausted  = exhausted_q;
    assign keys_done  = keys_done_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench: 4 cores, 4-bit keys, KEY_MAX=15, behavioural core responders.
module tb_key_search_scheduler;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [3:0]  core_done;
    logic [3:0]  core_found;
    logic [3:0]  core_start;
    logic [15:0] core_key;
    logic        core_abort;
    logic        busy;
    logic        found;
    logic [3:0]  found_key;
    logic        exhausted;
    logic [4:0]  keys_done;

    int checks = 0;
    int passes = 0;

    // Core responder configuration and observation counters.
    logic [15:0] found_en;
    int          delay [16];
    int          timer [4];
    logic [3:0]  cur_key [4];
    int          disp_cnt [16];
    int          total_starts;
    int          total_aborts;

    key_search_scheduler #(
        .NUM_CORES (4),
        .KEY_WIDTH (4),
        .KEY_MAX   (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .core_done  (core_done),
        .core_found (core_found),
        .core_start (core_start),
        .core_key   (core_key),
        .core_abort (core_abort),
        .busy       (busy),
        .found      (found),
        .found_key  (found_key),
        .exhausted  (exhausted),
        .keys_done  (keys_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each core finishes delay[key] cycles after its start pulse; abort/reset cancel.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            core_done[i]  = 1'b0;
            core_found[i] = 1'b0;
            if (!reset_n || core_abort) begin
                timer[i] = 0;
            end else if (timer[i] != 0) begin
                timer[i] = timer[i] - 1;
                if (timer[i] == 0) begin
                    core_done[i]  = 1'b1;
                    core_found[i] = found_en[cur_key[i]];
                end
            end
            if (reset_n && core_start[i]) begin
                cur_key[i] = core_key[i*4 +: 4];
                timer[i]   = delay[cur_key[i]];
            end
        end
    end

    // Dispatch and abort monitor.
    always @(negedge clk) begin
        if (core_abort) total_aborts = total_aborts + 1;
        for (int i = 0; i < 4; i++) begin
            if (core_start[i]) begin
                total_starts = total_starts + 1;
                disp_cnt[core_key[i*4 +: 4]] = disp_cnt[core_key[i*4 +: 4]] + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        total_starts = 0;
        total_aborts = 0;
        for (int k = 0; k < 16; k++) disp_cnt[k] = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        found_en = '0;
        for (int k = 0; k < 16; k++) delay[k] = 10;
        for (int i = 0; i < 4; i++) begin timer[i] = 0; cur_key[i] = '0; end
        clear_counts();
        repeat (3) tick();
        checks++; if (core_start !== 4'b0) $display("FAIL reset_core_start: got %b, expected 0000", core_start); else passes++;
        checks++; if (core_key !== 16'h0) $display("FAIL reset_core_key: got %h, expected 0000", core_key); else passes++;
        checks++; if (core_abort !== 1'b0) $display("FAIL reset_core_abort: got %b, expected 0", core_abort); else passes++;
        checks++; if ({busy, found, exhausted} !== 3'b000) $display("FAIL reset_flags: got %b, expected 000", {busy, found, exhausted}); else passes++;
        checks++; if (found_key !== 4'h0) $display("FAIL reset_found_key: got %h, expected 0", found_key); else passes++;
        checks++; if (keys_done !== 5'd0) $display("FAIL reset_keys_done: got %0d, expected 0", keys_done); else passes++;
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if ({busy, core_start} !== 5'b0) $display("FAIL idle_after_reset: got %b, expected 00000", {busy, core_start}); else passes++;
    endtask

    task automatic test_exhaust();
        int cyc;
        int bad;
        logic prev_busy;
        clear_counts();
        pulse_start();
        cyc = 1;
        checks++; if (core_start !== 4'b0001 || core_key[3:0] !== 4'd0 || busy !== 1'b1)
            $display("FAIL dispatch_c0: got start=%b key=%0d busy=%b, expected 0001/0/1", core_start, core_key[3:0], busy); else passes++;
        tick(); cyc++;
        checks++; if (core_start !== 4'b0010 || core_key[7:4] !== 4'd1)
            $display("FAIL dispatch_c1: got start=%b key=%0d, expected 0010/1", core_start, core_key[7:4]); else passes++;
        tick(); cyc++;
        checks++; if (core_start !== 4'b0100 || core_key[11:8] !== 4'd2)
            $display("FAIL dispatch_c2: got start=%b key=%0d, expected 0100/2", core_start, core_key[11:8]); else passes++;
        tick(); cyc++;
        checks++; if (core_start !== 4'b1000 || core_key[15:12] !== 4'd3)
            $display("FAIL dispatch_c3: got start=%b key=%0d, expected 1000/3", core_start, core_key[15:12]); else passes++;
        while (cyc < 19) begin tick(); cyc++; end
        // start while searching must be ignored
        pulse_start(); cyc++;
        prev_busy = busy;
        while (!exhausted && cyc < 200) begin
            prev_busy = busy;
            tick(); cyc++;
        end
        checks++; if (cyc !== 51) $display("FAIL exhaust_cycle: got %0d, expected 51", cyc); else passes++;
        checks++; if (busy !== 1'b0 || prev_busy !== 1'b1) $display("FAIL exhaust_busy_drop: got prev=%b now=%b, expected 1 then 0", prev_busy, busy); else passes++;
        checks++; if (keys_done !== 5'd16) $display("FAIL exhaust_keys_done: got %0d, expected 16", keys_done); else passes++;
        checks++; if (found !== 1'b0) $display("FAIL exhaust_found: got %b, expected 0", found); else passes++;
        checks++; if (total_starts !== 16) $display("FAIL exhaust_total_starts: got %0d, expected 16", total_starts); else passes++;
        bad = 0;
        for (int k = 0; k < 16; k++) if (disp_cnt[k] != 1) bad++;
        checks++; if (bad !== 0) $display("FAIL exhaust_each_key_once: got %0d bad keys, expected 0", bad); else passes++;
        checks++; if (core_key !== 16'hFEDC) $display("FAIL exhaust_last_keys: got %h, expected FEDC", core_key); else passes++;
    endtask

    task automatic test_found_single();
        int cyc;
        int aborts_at_hit;
        found_en = '0;
        found_en[6] = 1'b1;
        clear_counts();
        pulse_start();
        cyc = 1;
        checks++; if (exhausted !== 1'b0 || keys_done !== 5'd0 || core_start !== 4'b0001)
            $display("FAIL restart_from_exhausted: got exh=%b kd=%0d start=%b, expected 0/0/0001", exhausted, keys_done, core_start); else passes++;
        while (!found && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc !== 26) $display("FAIL found_latency: got cycle %0d, expected 26", cyc); else passes++;
        checks++; if (found_key !== 4'd6) $display("FAIL found_key_single: got %0d, expected 6", found_key); else passes++;
        checks++; if (core_abort !== 1'b1 || busy !== 1'b0) $display("FAIL found_abort: got abort=%b busy=%b, expected 1/0", core_abort, busy); else passes++;
        aborts_at_hit = total_aborts;
        tick();
        checks++; if (core_abort !== 1'b0) $display("FAIL abort_one_cycle: got %b, expected 0", core_abort); else passes++;
        repeat (30) tick();
        checks++; if (total_starts !== 9) $display("FAIL no_start_after_found: got %0d starts, expected 9", total_starts); else passes++;
        checks++; if (total_aborts !== aborts_at_hit || aborts_at_hit !== 1) $display("FAIL abort_count: got %0d, expected 1", total_aborts); else passes++;
        checks++; if (found !== 1'b1 || found_key !== 4'd6) $display("FAIL found_sticky: got found=%b key=%0d, expected 1/6", found, found_key); else passes++;
    endtask

    task automatic test_found_priority();
        int cyc;
        found_en = '0;
        found_en[9] = 1'b1;
        found_en[11] = 1'b1;
        delay[9] = 12;
        clear_counts();
        pulse_start();
        cyc = 1;
        checks++; if (found !== 1'b0) $display("FAIL restart_clears_found: got %b, expected 0", found); else passes++;
        while (!found && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc !== 39) $display("FAIL dual_found_cycle: got %0d, expected 39", cyc); else passes++;
        checks++; if (found_key !== 4'd9) $display("FAIL dual_found_key: got %0d, expected 9", found_key); else passes++;
        checks++; if (core_abort !== 1'b1) $display("FAIL dual_found_abort: got %b, expected 1", core_abort); else passes++;
        delay[9] = 10;
        repeat (5) tick();
    endtask

    task automatic test_stop();
        int cyc;
        int starts_at_stop;
        found_en = '0;
        delay[5] = 15;
        clear_counts();
        pulse_start();
        cyc = 1;
        while (cyc < 24) begin tick(); cyc++; end
        checks++; if (keys_done !== 5'd5) $display("FAIL keys_done_before_stop: got %0d, expected 5", keys_done); else passes++;
        stop = 1'b1;
        tick(); cyc++;
        stop = 1'b0;
        checks++; if (core_abort !== 1'b1 || busy !== 1'b0) $display("FAIL stop_abort: got abort=%b busy=%b, expected 1/0", core_abort, busy); else passes++;
        starts_at_stop = total_starts;
        repeat (10) tick();
        checks++; if (keys_done !== 5'd5) $display("FAIL stop_keys_frozen: got %0d, expected 5", keys_done); else passes++;
        checks++; if (total_starts !== starts_at_stop || found !== 1'b0) $display("FAIL stop_idle: got starts +%0d found=%b, expected +0/0", total_starts - starts_at_stop, found); else passes++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (core_abort !== 1'b0) $display("FAIL stop_in_idle: got abort=%b, expected 0", core_abort); else passes++;
        delay[5] = 10;
        pulse_start();
        checks++; if (keys_done !== 5'd0 || core_start !== 4'b0001 || core_key[3:0] !== 4'd0)
            $display("FAIL restart_after_stop: got kd=%0d start=%b key=%0d, expected 0/0001/0", keys_done, core_start, core_key[3:0]); else passes++;
    endtask

    task automatic test_reset_mid();
        int starts_at_reset;
        tick();
        tick();
        checks++; if (core_start !== 4'b0100) $display("FAIL pre_reset_dispatch: got %b, expected 0100", core_start); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (core_start !== 4'b0 || core_key !== 16'h0 || busy !== 1'b0 || keys_done !== 5'd0)
            $display("FAIL async_reset: got start=%b key=%h busy=%b kd=%0d, expected all 0", core_start, core_key, busy, keys_done); else passes++;
        starts_at_reset = total_starts;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        checks++; if (total_starts !== starts_at_reset || busy !== 1'b0) $display("FAIL no_restart_after_reset: got starts +%0d busy=%b, expected +0/0", total_starts - starts_at_reset, busy); else passes++;
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_found_single();
        test_found_priority();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/key_search_scheduler.md
Name: key_search_scheduler

Overview:
- Sequences the RC4 key-space search across NUM_CORES parallel decryption cores.
- Hands each idle core the next candidate secret key, collects done/found results, and halts every core on the first key that yields valid plaintext.
- Sits between the switch/start control and the decryption core array.
- Drives the status used for LEDR/HEX display.

Parameters:
NUM_CORES, 4, number of decryption cores scheduled (1..8)
KEY_WIDTH, 24, width of the secret key handed to a core
KEY_MAX, 24'h3FFFFF, last candidate key searched (inclusive); search starts at 0

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new search from key 0
stop  in  1  one-cycle pulse: abandon search, return to idle
core_done  in  NUM_CORES  per-core one-cycle pulse: current key finished
core_found  in  NUM_CORES  per-core qualifier, valid with core_done: key produced valid plaintext
core_start  out  NUM_CORES  per-core one-cycle pulse: begin decrypting core_key
core_key  out  NUM_CORES*KEY_WIDTH  per-core key; core i uses bits [i*KEY_WIDTH +: KEY_WIDTH]
core_abort  out  1  one-cycle pulse: all cores drop current work
busy  out  1  search in progress
found  out  1  sticky: a valid key was found
found_key  out  KEY_WIDTH  the winning key, valid while found=1
exhausted  out  1  sticky: all keys 0..KEY_MAX tried, none valid
keys_done  out  KEY_WIDTH+1  count of keys completed in this search

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; next_key=0; core_busy mask=0.
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- IDLE: start -> RUN; clear found, exhausted, keys_done, next_key, core_busy.
- RUN, dispatch:
  - Each cycle, if some core is idle and next_key<=KEY_MAX, pick the lowest-index idle core.
  - Drive its core_key=next_key and pulse core_start for 1 cycle; set its busy bit; next_key++.
  - At most one dispatch per cycle.
  - core_key is held stable until that core's next dispatch.
- RUN, completion:
  - core_done[i] clears busy[i] in the same cycle and increments keys_done.
  - Several simultaneous done pulses all count; keys_done adds popcount.
  - A core whose done arrives in cycle t is re-dispatchable from cycle t+1, never the same cycle.
- Found:
  - Any core_done[i]&core_found[i] -> latch found_key=core_key[i].
  - If several are found in one cycle, take the lowest index.
  - found=1, pulse core_abort, clear busy mask, go to FOUND.
  - No dispatch occurs in that cycle.
- Key exhaustion: next_key>KEY_MAX with busy mask nonzero -> DRAIN; no further dispatch.
  - next_key is KEY_WIDTH+1 bits so KEY_MAX=all-ones does not wrap.
- DRAIN:
  - Completions are handled as in RUN; found -> FOUND.
  - Busy mask reaching 0 with nothing found -> exhausted=1, go to EXHAUSTED.
- FOUND / EXHAUSTED: hold outputs; start -> restart as from IDLE (clears sticky flags).
- busy=1 in RUN and DRAIN only.
- stop:
  - In RUN or DRAIN: pulse core_abort, clear busy mask, go to IDLE.
  - Sticky flags keep their values; keys_done is frozen.
  - Ignored in other states.
- Simultaneous stop and found in the same cycle: found wins (latch key, go to FOUND).
- start while RUN/DRAIN: ignored.
- core_done for a core whose busy bit is 0: ignored, no count.
- Reset mid-search: immediate return to IDLE; cores are reset by the same reset_n.
- Latency:
  - start in cycle t -> core 0 core_start at t+1, core 1 at t+2, and so on.
  - core_done/found at t -> found=1 and core_abort at t+1.

Decomposition:
- Package rc4_pkg: KEY_WIDTH default, sched_state_t enum, KEY_MAX_DEFAULT constant.
- Sub-module core_picker: combinational lowest-index selection from the idle mask, plus popcount of done pulses.
  - Reused for found-priority encoding.

Test Plan:
- NUM_CORES=4, KEY_MAX=15, cores always done 10 cycles after start, never found -> keys 0..15 each dispatched once; exhausted=1; keys_done=16; busy drops after the last done.
- Core 2 reports found on key 6 -> found=1, found_key=6, core_abort pulsed once; no further core_start.
- Cores 1 and 3 report found in the same cycle (keys 9 and 11) -> found_key=9.
- stop during RUN after 5 keys done -> IDLE, core_abort pulse, keys_done=5; a later start restarts at key 0 and clears keys_done.
- KEY_WIDTH=4, KEY_MAX=4'hF -> no wrap past 15; exhausted after 16 keys.
- reset_n asserted mid-dispatch -> all outputs 0 asynchronously; core_start is not re-pulsed until a new start.
